// File: rtl/four_12_12_st0_st_activation.sv
// -----------------------------------------------------------------------------
// four_12_12_st0_st_activation
//
// Activation and output buffer for one neuron. It sits after the stage-0 bias
// adder. Each valid bias-adder result passes through a selectable activation
// (bypass, ReLU, or power-of-two leaky ReLU). It is tagged with an
// end-of-vector marker and queued in a small FIFO. The FIFO drives the next
// layer over a ready/valid handshake. The upstream adder cannot be stalled, so
// a sample that reaches a full FIFO with no read is dropped and the sticky
// overflow flag is set.
//
// Floats are float_24_8 packed as {sgn, exp[7:0], man[22:0]}.
//
// Ports:
//   clk                          in   rising-edge clock
//   reset                        in   synchronous, active-high
//   four_12_12_st0_st_bias_adder in   [31:0] bias-adder result
//   bias_add_valid               in   input sample valid
//   act_mode                     in   [1:0] 0 bypass, 1 ReLU, 2 leaky, 3 bypass
//   leak_shift                   in   [3:0] leaky slope exponent (x * 2^-shift)
//   four_12_12_st0_st_act_out    out  [31:0] FIFO head data
//   out_valid                    out  FIFO not empty
//   out_last                     out  head sample closes a vector
//   out_ready                    in   consumer accepts head when out_valid
//   fifo_count                   out  [clog2(DEPTH):0] occupancy
//   overflow                     out  sticky sample-dropped flag
//
// Latency: the input is captured at edge N and written into the FIFO at edge
// N+1, so out_valid is high after edge N+1.
// -----------------------------------------------------------------------------
module four_12_12_st0_st_activation #(
    parameter int DEPTH      = 4,
    parameter int VECTOR_LEN = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              four_12_12_st0_st_bias_adder,
    input  logic                     bias_add_valid,
    input  logic [1:0]               act_mode,
    input  logic [3:0]               leak_shift,
    output logic [31:0]              four_12_12_st0_st_act_out,
    output logic                     out_valid,
    output logic                     out_last,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int VCW = (VECTOR_LEN > 1) ? $clog2(VECTOR_LEN) : 1;

    // Activation on a float_24_8 word. Any result with exp == 0 is forced to
    // all-zero bits, so the block never emits a negative zero.
    function automatic logic [31:0] f_activate(
        input logic [31:0] x,
        input logic [1:0]  mode,
        input logic [3:0]  sh
    );
        logic        sgn;
        logic [7:0]  e;
        logic [22:0] m;
        logic [31:0] y;
        sgn = x[31];
        e   = x[30:23];
        m   = x[22:0];
        y   = x;
        if (e == 8'd0) begin
            y = '0;
        end else if (mode == 2'd1 && sgn) begin
            y = '0;
        end else if (mode == 2'd2 && sgn) begin
            // Scaling by 2^-sh only lowers the exponent. If it would reach
            // zero or below, the result underflows to zero.
            if (e > {4'd0, sh}) begin
                y = {1'b1, e - {4'd0, sh}, m};
            end else begin
                y = '0;
            end
        end
        return y;
    endfunction

    logic [VCW-1:0] r_vcnt;
    logic           r_vld_p1;
    logic [31:0]    r_data_p1;
    logic           r_last_p1;

    logic [32:0]    r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic           r_overflow;

    logic           w_rd;
    logic           w_full;
    logic           w_wr;
    logic           w_drop;

    // ---- S1: activation capture and vector framing ----
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld_p1 <= 1'b0;
            r_vcnt   <= '0;
        end else begin
            r_vld_p1 <= bias_add_valid;
            if (bias_add_valid) begin
                // The counter follows the upstream cadence even when this
                // sample is later dropped at the FIFO.
                if (r_vcnt == VCW'(VECTOR_LEN - 1)) begin
                    r_vcnt <= '0;
                end else begin
                    r_vcnt <= r_vcnt + VCW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (bias_add_valid) begin
            r_data_p1 <= f_activate(four_12_12_st0_st_bias_adder, act_mode, leak_shift);
            r_last_p1 <= (r_vcnt == VCW'(VECTOR_LEN - 1));
        end
    end

    // ---- S2: output FIFO ----
    assign w_rd   = (r_count != '0) && out_ready;
    assign w_full = (r_count == CW'(DEPTH));
    // A read in the same cycle frees a slot, so a full FIFO still accepts it.
    assign w_wr   = r_vld_p1 && (!w_full || w_rd);
    assign w_drop = r_vld_p1 && w_full && !w_rd;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            // Storage is cleared so the head reads as zero after reset.
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= {r_last_p1, r_data_p1};
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_wr) - CW'(w_rd);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign four_12_12_st0_st_act_out = r_mem[r_rd_ptr][31:0];
    assign out_last                  = r_mem[r_rd_ptr][32];
    assign out_valid                 = (r_count != '0);
    assign fifo_count                = r_count;
    assign overflow                  = r_overflow;

endmodule

// File: tb/tb_four_12_12_st0_st_activation.sv
// -----------------------------------------------------------------------------
// Testbench for four_12_12_st0_st_activation. A small cycle model tracks the
// S1 stage and the FIFO contents. It computes each expected result when the
// stimulus is driven, queues it, and compares the queue head with the DUT.
// -----------------------------------------------------------------------------
module tb_four_12_12_st0_st_activation;

    localparam int DEPTH = 4;
    localparam int VLEN  = 12;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] din;
    logic        bias_add_valid;
    logic [1:0]  act_mode;
    logic [3:0]  leak_shift;
    logic [31:0] dout;
    logic        out_valid;
    logic        out_last;
    logic        out_ready;
    logic [2:0]  fifo_count;
    logic        overflow;

    four_12_12_st0_st_activation #(.DEPTH(DEPTH), .VECTOR_LEN(VLEN)) dut (
        .clk                          (clk),
        .reset                        (reset),
        .four_12_12_st0_st_bias_adder (din),
        .bias_add_valid               (bias_add_valid),
        .act_mode                     (act_mode),
        .leak_shift                   (leak_shift),
        .four_12_12_st0_st_act_out    (dout),
        .out_valid                    (out_valid),
        .out_last                     (out_last),
        .out_ready                    (out_ready),
        .fifo_count                   (fifo_count),
        .overflow                     (overflow)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [32:0] sb_q[$];
    logic        m_vld   = 1'b0;
    logic [32:0] m_ent   = '0;
    int          m_vcnt  = 0;
    logic        m_ovf   = 1'b0;
    bit          m_known = 1'b0;

    function automatic logic [31:0] ref_act(input logic [31:0] x, input logic [1:0] md,
                                            input logic [3:0] sh);
        int ne;
        if (x[30:23] == 8'd0) return 32'h0;
        case (md)
            2'd1: return x[31] ? 32'h0 : x;
            2'd2: begin
                if (!x[31]) return x;
                ne = int'(x[30:23]) - int'(sh);
                if (ne <= 0) return 32'h0;
                return {1'b1, 8'(ne), x[22:0]};
            end
            default: return x;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_now();
        if (m_known) begin
            chk("out_valid", {32'h0, out_valid}, {32'h0, sb_q.size() != 0});
            chk("fifo_count", {30'h0, fifo_count}, 33'(sb_q.size()));
            chk("overflow", {32'h0, overflow}, {32'h0, m_ovf});
            if (sb_q.size() != 0) begin
                chk("head_data", {1'b0, dout}, {1'b0, sb_q[0][31:0]});
                chk("head_last", {32'h0, out_last}, {32'h0, sb_q[0][32]});
            end
        end
    endtask

    task automatic step(input logic v, input logic [31:0] d, input logic [1:0] md,
                        input logic [3:0] sh, input logic rdy, input logic rst_i);
        reset          = rst_i;
        bias_add_valid = v;
        din            = d;
        act_mode       = md;
        leak_shift     = sh;
        out_ready      = rdy;
        check_now();
        if (rst_i) begin
            sb_q.delete();
            m_vld   = 1'b0;
            m_vcnt  = 0;
            m_ovf   = 1'b0;
            m_known = 1'b1;
        end else begin
            if (sb_q.size() != 0 && rdy) void'(sb_q.pop_front());
            if (m_vld) begin
                if (sb_q.size() < DEPTH) sb_q.push_back(m_ent);
                else m_ovf = 1'b1;
            end
            m_vld = v;
            if (v) begin
                m_ent  = {(m_vcnt == VLEN - 1), ref_act(d, md, sh)};
                m_vcnt = (m_vcnt + 1) % VLEN;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 32'h0, 2'd0, 4'd0, rdy, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 32'h0, 2'd0, 4'd0, 1'b1, 1'b1);
    endtask

    task automatic reset_check();
        chk("rst_valid", {32'h0, out_valid}, 33'h0);
        chk("rst_last", {32'h0, out_last}, 33'h0);
        chk("rst_data", {1'b0, dout}, 33'h0);
        chk("rst_count", {30'h0, fifo_count}, 33'h0);
        chk("rst_overflow", {32'h0, overflow}, 33'h0);
    endtask

    initial begin
        reset = 1'b1; bias_add_valid = 1'b0; din = '0;
        act_mode = '0; leak_shift = '0; out_ready = 1'b0;
        #1;
        do_reset();
        do_reset();
        reset_check();

        // Bypass of 1.0
        step(1'b1, 32'h3F800000, 2'd0, 4'd0, 1'b1, 1'b0);
        repeat (3) idle(1'b1);

        // ReLU: -2.0 then 3.0
        step(1'b1, 32'hC0000000, 2'd1, 4'd0, 1'b1, 1'b0);
        step(1'b1, 32'h40400000, 2'd1, 4'd0, 1'b1, 1'b0);
        repeat (3) idle(1'b1);

        // Leaky and zero edge cases
        step(1'b1, 32'hC0000000, 2'd2, 4'd3, 1'b1, 1'b0);
        step(1'b1, {1'b1, 8'd2, 23'd5}, 2'd2, 4'd3, 1'b1, 1'b0);
        step(1'b1, {1'b1, 8'd3, 23'd1}, 2'd2, 4'd3, 1'b1, 1'b0);
        step(1'b1, {1'b1, 8'd4, 23'd7}, 2'd2, 4'd3, 1'b1, 1'b0);
        step(1'b1, 32'h40400000, 2'd2, 4'd3, 1'b1, 1'b0);
        step(1'b1, 32'hC0000000, 2'd2, 4'd0, 1'b1, 1'b0);
        step(1'b1, 32'h80000000, 2'd0, 4'd0, 1'b1, 1'b0);
        step(1'b1, 32'hC0400000, 2'd3, 4'd5, 1'b1, 1'b0);
        repeat (3) idle(1'b1);

        // Framing: 25 back-to-back samples from a fresh counter
        do_reset();
        for (int i = 0; i < 25; i++) begin
            step(1'b1, $urandom, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                 1'b1, 1'b0);
        end
        repeat (3) idle(1'b1);

        // Backpressure: 6 samples into a stalled FIFO, then drain
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 32'h41000000 + 32'(i), 2'd0, 4'd0, 1'b0, 1'b0);
        end
        repeat (2) idle(1'b0);
        repeat (6) idle(1'b1);

        // Full FIFO with simultaneous write and read, then mid-stream reset
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'h42000000 + 32'(i), 2'd0, 4'd0, 1'b0, 1'b0);
        end
        idle(1'b0);
        step(1'b1, 32'h42800000, 2'd0, 4'd0, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b0);
        step(1'b1, 32'h43000000, 2'd0, 4'd0, 1'b1, 1'b0);
        step(1'b1, 32'h43800000, 2'd0, 4'd0, 1'b1, 1'b1);
        reset_check();
        repeat (3) idle(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/four_12_12_st0_st_activation.md
# four_12_12_st0_st_activation

Per-neuron activation and output-buffer stage that sits directly downstream of the stage-0 bias adder. It takes the registered `float_24_8` bias-adder result and applies a selectable activation: bypass, ReLU or power-of-two leaky ReLU. Each result is tagged with an end-of-vector marker and queued in a small FIFO. The FIFO presents the results to the next layer over a ready/valid handshake and absorbs short stalls, because the bias adder itself has no backpressure.

## Interface
Parameters:
- `DEPTH`, 4: output FIFO entries; power of two, at least 2.
- `VECTOR_LEN`, 12: samples per output vector; sets the `out_last` cadence.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `four_12_12_st0_st_bias_adder`  in  float_24_8  bias-adder result (`sgn`, `exp[7:0]`, `man[22:0]`).
- `bias_add_valid`  in  1  input sample valid this cycle.
- `act_mode`  in  2  activation select: 0 bypass, 1 ReLU, 2 leaky, 3 reserved (treated as bypass).
- `leak_shift`  in  4  leaky slope exponent; negative inputs are scaled by 2^-leak_shift.
- `four_12_12_st0_st_act_out`  out  float_24_8  FIFO head data.
- `out_valid`  out  1  FIFO not empty.
- `out_last`  out  1  head sample is the final sample of a vector.
- `out_ready`  in  1  consumer accepts the head when `out_valid` is also high.
- `fifo_count`  out  clog2(DEPTH)+1  current occupancy.
- `overflow`  out  1  sticky: at least one sample was dropped.

## Operation
- A float is zero when `exp == 0`. Every zero this block emits is all-zero bits, including `sgn = 0`.
- Activation stage (S1 register), applied to the sample captured when `bias_add_valid` is high:
  - Bypass: output equals the input.
  - ReLU: `sgn = 1` gives zero. Otherwise the output equals the input. A zero input gives zero.
  - Leaky with `sgn = 0`: output equals the input.
  - Leaky with `sgn = 1` and `exp > leak_shift`: output is `{1, exp - leak_shift, man}`.
  - Leaky with `sgn = 1` and `exp <= leak_shift`: output is zero.
  - `leak_shift = 0` in leaky mode is a pass-through.
- `act_mode` and `leak_shift` are sampled in the same cycle as the data and travel with it. Changing them mid-vector is legal.
- Vector counter `vcnt`, range 0..VECTOR_LEN-1:
  - Increments on every accepted input sample and wraps to 0 after VECTOR_LEN-1.
  - The S1 last tag is set when `vcnt == VECTOR_LEN-1` at capture.
  - The counter advances even when that sample is later dropped, so vector framing follows the upstream cadence.
- FIFO write: a valid S1 entry is written into the FIFO on the following edge.
- FIFO read: occurs when `out_valid && out_ready`.
- Full FIFO:
  - If a write and a read happen in the same cycle while full, both complete and the count is unchanged.
  - If a write arrives while full and no read happens, the sample is dropped and `overflow` sets and stays set until reset. The count stays at DEPTH.
- Empty FIFO with a write and `out_ready` high: there is no bypass. Data appears the next cycle.
- Pointers wrap modulo DEPTH. `fifo_count` ranges 0..DEPTH.

## Timing
- Latency is 2 cycles from `bias_add_valid` to `out_valid`:
  - Edge N captures the input into S1.
  - Edge N+1 writes the FIFO.
  - `out_valid` is high after edge N+1.
- Sustained throughput is one sample per cycle while `out_ready` stays high.
- `out_valid`, `four_12_12_st0_st_act_out` and `out_last` are registered and hold stable while `out_valid && !out_ready`.
- Values after reset: `out_valid = 0`, `out_last = 0`, data `= 0`, `fifo_count = 0`, `overflow = 0`, `vcnt = 0`, S1 valid `= 0`.
- Reset asserted mid-operation:
  - The FIFO contents and any in-flight S1 sample are discarded.
  - An input with `bias_add_valid` high during a reset cycle is ignored.
- Reset has priority over all other events in the same cycle.

## Test plan
- Bypass: input `0x3F800000` (1.0) with valid, `out_ready = 1`. Expect `out_valid` 2 cycles later with data `0x3F800000` and `fifo_count` returning to 0.
- ReLU: stream `0xC0000000` (-2.0) then `0x40400000` (3.0). Expect outputs `0x00000000` then `0x40400000`.
- Leaky with `leak_shift = 3`:
  - Input `0xC0000000` → `0xBE800000`.
  - Input `{1, exp 2, man 5}` → `0x00000000` (exp 2 <= 3, so zero).
- Framing: 25 back-to-back valid samples with `out_ready = 1`. Expect `out_last` high on outputs 12 and 24 only.
- Backpressure:
  - Hold `out_ready = 0` and send 6 samples (DEPTH 4). Expect `fifo_count` saturating at 4 and `overflow` rising on sample 5.
  - Then release `out_ready`. Expect the first 4 samples to drain in order.
- Full plus simultaneous: with the FIFO full, write and read in the same cycle. Expect no overflow, count stays at 4, new data at the tail. Then assert reset mid-stream and expect every output to return to its reset value the next cycle.
